cache_miss_sched: RTL and testbench



---
 rtl/soc_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 54 +++++
 rtl/cache_miss_sched.sv | 190 +++++++++++++++++++
 tb/tb_cache_miss_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_pkg
// Description : Shared SoC types and cache geometry used by the miss
//               scheduler: threading mode, per-thread miss FSM states and
//               the default instruction-cache set/way counts.
// Revision    : 1.0 - initial release
// ============================================================================
package soc_pkg;

    localparam int ICACHE_NUM_SET      = 64;
    localparam int ICACHE_WAYS_PER_SET = 4;

    typedef enum logic {
        Single_Threaded = 1'b0,
        Multi_Threaded  = 1'b1
    } multithreading_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        WAIT = 2'd2,
        FILL = 2'd3
    } miss_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin arbiter. The search for a winner starts at the
//               pointer; when the owner consumes a grant (advance) the
//               pointer moves to winner+1.
// Ports       : clock, reset (async, active-low)
//               req     [N]  - request vector
//               advance      - grant consumed this cycle, rotate pointer
//               gnt     [N]  - one-hot grant (combinational)
//               gnt_id       - index of the granted requester (0 if none)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_id
);

    logic [W-1:0] ptr;

    always_comb begin : comb_pick
        logic         found;
        logic [W-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int i = 0; i < N; i++) begin
            idx = W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = idx;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(gnt_id) == N - 1) ? '0 : gnt_id + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_miss_sched.sv
`default_nettype none
// ============================================================================
// Module      : cache_miss_sched
// Description : Per-core miss scheduler. One outstanding miss per thread,
//               round-robin sharing of the memory request port through a
//               registered output slot, out-of-order tagged responses, and
//               round-robin refill sequencing through the LRU victim port
//               with a same-cycle LRU (_mt) update of the chosen way.
// Ports       : clock, reset (async, active-low), mt_mode
//               miss_req/miss_addr in, miss_busy/miss_done out
//               mem_req_valid/ready/addr/thread  - memory request port
//               mem_rsp_valid/thread             - tagged response
//               victim_req/set/thread, victim_way - LRU victim lookup
//               lru_upd_req/set/way/thread       - LRU update port
//               fill_valid/set/way/addr/thread   - array write command
//               proto_err                        - sticky error flag
// Revision    : 1.0 - initial release
// ============================================================================
module cache_miss_sched
    import soc_pkg::*;
#(
    parameter  int NUM_THREADS    = 4,
    parameter  int NUM_SET        = ICACHE_NUM_SET,
    parameter  int WAYS_PER_SET   = ICACHE_WAYS_PER_SET,
    parameter  int ADDR_W         = 32,
    localparam int NUM_SET_W      = $clog2(NUM_SET),
    localparam int WAYS_PER_SET_W = $clog2(WAYS_PER_SET),
    localparam int THR_W          = $clog2(NUM_THREADS)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  multithreading_mode_t                mt_mode,
    input  logic [NUM_THREADS-1:0]              miss_req,
    input  logic [NUM_THREADS-1:0][ADDR_W-1:0]  miss_addr,
    output logic [NUM_THREADS-1:0]              miss_busy,
    output logic [NUM_THREADS-1:0]              miss_done,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic [ADDR_W-1:0]                   mem_req_addr,
    output logic [THR_W-1:0]                    mem_req_thread,
    input  logic                                mem_rsp_valid,
    input  logic [THR_W-1:0]                    mem_rsp_thread,
    output logic                                victim_req,
    output logic [NUM_SET_W-1:0]                victim_set,
    output logic [THR_W-1:0]                    victim_thread,
    input  logic [WAYS_PER_SET_W-1:0]           victim_way,
    output logic                                lru_upd_req,
    output logic [NUM_SET_W-1:0]                lru_upd_set,
    output logic [WAYS_PER_SET_W-1:0]           lru_upd_way,
    output logic [THR_W-1:0]                    lru_upd_thread,
    output logic                                fill_valid,
    output logic [NUM_SET_W-1:0]                fill_set,
    output logic [WAYS_PER_SET_W-1:0]           fill_way,
    output logic [ADDR_W-1:0]                   fill_addr,
    output logic [THR_W-1:0]                    fill_thread,
    output logic                                proto_err
);

    miss_state_t               state     [NUM_THREADS];
    miss_state_t               state_nxt [NUM_THREADS];
    logic [ADDR_W-1:0]         line_addr [NUM_THREADS];
    logic [NUM_THREADS-1:0]    capture;
    logic [NUM_THREADS-1:0]    pend_vec;
    logic [NUM_THREADS-1:0]    fill_vec;
    logic [NUM_THREADS-1:0]    slot_mask;
    logic [NUM_THREADS-1:0]    mem_gnt;
    logic [NUM_THREADS-1:0]    vic_gnt;
    logic [THR_W-1:0]          mem_gnt_id;
    logic [THR_W-1:0]          vic_gnt_id;
    logic                      handshake;
    logic                      slot_load;
    logic                      mem_adv;
    logic                      rsp_err;

    assign handshake = mem_req_valid & mem_req_ready;
    assign slot_load = ~mem_req_valid | mem_req_ready;
    assign mem_adv   = slot_load & (|mem_gnt);
    assign rsp_err   = mem_rsp_valid & (state[mem_rsp_thread] != WAIT);

    // Per-thread next state. The thread currently held in the output slot
    // is still PEND but must not compete again, hence slot_mask.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            state_nxt[t] = state[t];
            capture[t]   = 1'b0;
            slot_mask[t] = mem_req_valid && (mem_req_thread == THR_W'(t));
            pend_vec[t]  = (state[t] == PEND) && !slot_mask[t];
            fill_vec[t]  = (state[t] == FILL);
            miss_busy[t] = (state[t] != IDLE);
            case (state[t])
                IDLE: if (miss_req[t] && (t == 0 || mt_mode != Single_Threaded)) begin
                    capture[t]   = 1'b1;
                    state_nxt[t] = PEND;
                end
                PEND: if (handshake && mem_req_thread == THR_W'(t)) begin
                    state_nxt[t] = WAIT;
                end
                WAIT: if (mem_rsp_valid && mem_rsp_thread == THR_W'(t)) begin
                    state_nxt[t] = FILL;
                end
                FILL: if (vic_gnt[t]) begin
                    state_nxt[t] = IDLE;
                end
                default: state_nxt[t] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state[t]     <= IDLE;
                line_addr[t] <= '0;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                state[t] <= state_nxt[t];
                if (capture[t]) begin
                    line_addr[t] <= miss_addr[t];
                end
            end
        end
    end

    rr_arbiter #(.N(NUM_THREADS)) u_mem_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (pend_vec),
        .advance (mem_adv),
        .gnt     (mem_gnt),
        .gnt_id  (mem_gnt_id)
    );

    rr_arbiter #(.N(NUM_THREADS)) u_vic_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (fill_vec),
        .advance (victim_req),
        .gnt     (vic_gnt),
        .gnt_id  (vic_gnt_id)
    );

    // Memory request slot: held until accepted, reloaded when empty or on
    // the accepting edge so back-to-back requests issue every cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_req_valid  <= 1'b0;
            mem_req_addr   <= '0;
            mem_req_thread <= '0;
        end else if (slot_load) begin
            mem_req_valid  <= |mem_gnt;
            mem_req_addr   <= (|mem_gnt) ? line_addr[mem_gnt_id] : '0;
            mem_req_thread <= mem_gnt_id;
        end
    end

    // Victim lookup and LRU update share the grant cycle, so the LRU sees
    // the filled way as MRU before the next grant to the same set.
    assign victim_req     = |vic_gnt;
    assign victim_thread  = vic_gnt_id;
    assign victim_set     = victim_req ? line_addr[vic_gnt_id][NUM_SET_W-1:0] : '0;
    assign lru_upd_req    = victim_req;
    assign lru_upd_set    = victim_set;
    assign lru_upd_way    = victim_req ? victim_way : '0;
    assign lru_upd_thread = victim_thread;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fill_valid  <= 1'b0;
            fill_set    <= '0;
            fill_way    <= '0;
            fill_addr   <= '0;
            fill_thread <= '0;
            miss_done   <= '0;
            proto_err   <= 1'b0;
        end else begin
            fill_valid  <= victim_req;
            fill_set    <= victim_set;
            fill_way    <= lru_upd_way;
            fill_addr   <= victim_req ? line_addr[vic_gnt_id] : '0;
            fill_thread <= victim_thread;
            miss_done   <= vic_gnt;
            if (rsp_err) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_miss_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_cache_miss_sched
// Description : Self-checking bench for cache_miss_sched: a cycle table for a
//               single-thread miss plus directed multi-cycle sequences
//               (round-robin, backpressure, out-of-order and same-set fills,
//               protocol errors, reset in WAIT, single-threaded mode).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_miss_sched;
    import soc_pkg::*;

    localparam int NT = 4;
    localparam int AW = 32;
    localparam int SW = 6;
    localparam int WW = 2;
    localparam int TW = 2;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    multithreading_mode_t  mt_mode = Multi_Threaded;
    logic [NT-1:0]         miss_req;
    logic [NT-1:0][AW-1:0] miss_addr;
    logic [NT-1:0]         miss_busy, miss_done;
    logic                  mem_req_valid, mem_req_ready;
    logic [AW-1:0]         mem_req_addr;
    logic [TW-1:0]         mem_req_thread;
    logic                  mem_rsp_valid;
    logic [TW-1:0]         mem_rsp_thread;
    logic                  victim_req;
    logic [SW-1:0]         victim_set;
    logic [TW-1:0]         victim_thread;
    logic [WW-1:0]         victim_way;
    logic                  lru_upd_req;
    logic [SW-1:0]         lru_upd_set;
    logic [WW-1:0]         lru_upd_way;
    logic [TW-1:0]         lru_upd_thread;
    logic                  fill_valid;
    logic [SW-1:0]         fill_set;
    logic [WW-1:0]         fill_way;
    logic [AW-1:0]         fill_addr;
    logic [TW-1:0]         fill_thread;
    logic                  proto_err;

    always #5 clock = ~clock;

    cache_miss_sched dut (
        .clock(clock), .reset(reset), .mt_mode(mt_mode),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_busy(miss_busy), .miss_done(miss_done),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_thread(mem_req_thread),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_thread(mem_rsp_thread),
        .victim_req(victim_req), .victim_set(victim_set),
        .victim_thread(victim_thread), .victim_way(victim_way),
        .lru_upd_req(lru_upd_req), .lru_upd_set(lru_upd_set),
        .lru_upd_way(lru_upd_way), .lru_upd_thread(lru_upd_thread),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
        .fill_addr(fill_addr), .fill_thread(fill_thread),
        .proto_err(proto_err)
    );

    typedef struct {
        logic [3:0]  miss;
        logic        rdy;
        logic        rv;
        logic [1:0]  rt;
        logic [3:0]  busy;
        logic        mv;
        logic [31:0] ma;
        logic [1:0]  mt;
        logic        vr;
        logic [5:0]  vs;
        logic [1:0]  lw;
        logic        fv;
        logic [1:0]  fw;
        logic [31:0] fa;
        logic [3:0]  done;
        logic        perr;
    } vec_t;

    vec_t vecs [13];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clr_inputs();
        miss_req       = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_thread = '0;
        victim_way     = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        clr_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clock);
        clr_inputs();
    endtask

    task automatic rsp(input int t);
        mem_rsp_valid  = 1'b1;
        mem_rsp_thread = TW'(t);
    endtask

    function automatic logic [127:0] vic_pack();
        return {victim_req, victim_thread, victim_set, lru_upd_req,
                lru_upd_set, lru_upd_way, lru_upd_thread};
    endfunction

    function automatic logic [127:0] fill_pack();
        return {fill_valid, fill_thread, fill_addr, fill_way, fill_set, miss_done};
    endfunction

    function automatic logic [127:0] all_out();
        return {miss_busy, miss_done, mem_req_valid, mem_req_addr, mem_req_thread,
                victim_req, victim_set, victim_thread, lru_upd_req, lru_upd_set,
                lru_upd_way, lru_upd_thread, fill_valid, fill_set, fill_way,
                fill_addr, fill_thread, proto_err};
    endfunction

    initial begin
        int hs;
        logic [127:0] act, exp;

        //            miss  rdy rv rt  busy mv ma     mt vr vs lw fv fw fa     done perr
        vecs[0]  = '{4'h1, 1, 0, 0, 4'h0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[1]  = '{4'h0, 1, 0, 0, 4'h1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[2]  = '{4'h0, 1, 0, 0, 4'h1, 1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[3]  = '{4'h0, 1, 0, 0, 4'h1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[4]  = '{4'h0, 1, 0, 0, 4'h1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[5]  = '{4'h0, 1, 0, 0, 4'h1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[6]  = '{4'h0, 1, 1, 0, 4'h1, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[7]  = '{4'h0, 1, 0, 0, 4'h1, 0, 32'h0,  0, 1, 0, 3, 0, 0, 32'h0,  4'h0, 0};
        vecs[8]  = '{4'h0, 1, 0, 0, 4'h0, 0, 32'h0,  0, 0, 0, 0, 1, 3, 32'h40, 4'h1, 0};
        vecs[9]  = '{4'h0, 1, 0, 0, 4'h0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[10] = '{4'h0, 1, 1, 2, 4'h0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 0};
        vecs[11] = '{4'h0, 1, 0, 0, 4'h0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 1};
        vecs[12] = '{4'h0, 1, 0, 0, 4'h0, 0, 32'h0,  0, 0, 0, 0, 0, 0, 32'h0,  4'h0, 1};

        miss_addr = '0;
        clr_inputs();
        #1;
        chk("reset_outputs", all_out(), 128'h0);

        // Single-thread miss on t0, line 0x40, LRU always answers way 3.
        do_reset();
        mt_mode      = Multi_Threaded;
        miss_addr[0] = 32'h40;
        for (int i = 0; i < 13; i++) begin
            cyc();
            miss_req       = vecs[i].miss;
            mem_req_ready  = vecs[i].rdy;
            mem_rsp_valid  = vecs[i].rv;
            mem_rsp_thread = vecs[i].rt;
            victim_way     = 2'd3;
            #1;
            act = {miss_busy, mem_req_valid,
                   mem_req_valid ? mem_req_addr : 32'h0,
                   mem_req_valid ? mem_req_thread : 2'd0,
                   victim_req, lru_upd_req,
                   victim_req ? victim_set : 6'd0,
                   lru_upd_req ? lru_upd_set : 6'd0,
                   lru_upd_req ? lru_upd_way : 2'd0,
                   fill_valid,
                   fill_valid ? fill_way : 2'd0,
                   fill_valid ? fill_addr : 32'h0,
                   miss_done, proto_err};
            exp = {vecs[i].busy, vecs[i].mv, vecs[i].ma, vecs[i].mt,
                   vecs[i].vr, vecs[i].vr, vecs[i].vs, vecs[i].vs, vecs[i].lw,
                   vecs[i].fv, vecs[i].fw, vecs[i].fa, vecs[i].done, vecs[i].perr};
            chk($sformatf("table_c%0d", i), act, exp);
        end

        // Round-robin issue, out-of-order responses, back-to-back same-set fills.
        do_reset();
        miss_addr = {32'h7C5, 32'h3A, 32'h205, 32'h40};
        cyc(); miss_req = 4'hF; mem_req_ready = 1'b1; #1;
        cyc(); mem_req_ready = 1'b1; #1;
        chk("rr_busy", miss_busy, 4'hF);
        for (int t = 0; t < 4; t++) begin
            cyc(); mem_req_ready = 1'b1; #1;
            chk($sformatf("rr_issue_t%0d", t), {mem_req_valid, mem_req_thread, mem_req_addr},
                {1'b1, TW'(t), miss_addr[t]});
        end
        cyc(); mem_req_ready = 1'b1; #1;
        chk("rr_drained", mem_req_valid, 1'b0);
        cyc(); rsp(2); #1;
        cyc(); rsp(0); victim_way = 2'd1; #1;
        chk("ooo_grant_t2", vic_pack(), {1'b1, 2'd2, 6'd58, 1'b1, 6'd58, 2'd1, 2'd2});
        cyc(); victim_way = 2'd2; #1;
        chk("ooo_grant_t0", vic_pack(), {1'b1, 2'd0, 6'd0, 1'b1, 6'd0, 2'd2, 2'd0});
        chk("ooo_fill_t2", fill_pack(), {1'b1, 2'd2, 32'h3A, 2'd1, 6'd58, 4'b0100});
        cyc(); rsp(1); #1;
        chk("ooo_fill_t0", fill_pack(), {1'b1, 2'd0, 32'h40, 2'd2, 6'd0, 4'b0001});
        cyc(); rsp(3); victim_way = 2'd0; #1;
        chk("set5_grant_t1", vic_pack(), {1'b1, 2'd1, 6'd5, 1'b1, 6'd5, 2'd0, 2'd1});
        cyc(); victim_way = 2'd1; #1;
        chk("set5_grant_t3", vic_pack(), {1'b1, 2'd3, 6'd5, 1'b1, 6'd5, 2'd1, 2'd3});
        chk("set5_fill_t1", fill_pack(), {1'b1, 2'd1, 32'h205, 2'd0, 6'd5, 4'b0010});
        cyc(); #1;
        chk("set5_fill_t3", fill_pack(), {1'b1, 2'd3, 32'h7C5, 2'd1, 6'd5, 4'b1000});
        cyc(); #1;
        chk("set5_quiet", {miss_busy, miss_done, fill_valid, proto_err}, 10'h0);

        // Backpressure, then a response landing in the handshake cycle.
        do_reset();
        miss_addr[1] = 32'h123;
        hs = 0;
        cyc(); miss_req = 4'b0010; #1;
        cyc(); #1;
        chk("bp_pend", {miss_busy, mem_req_valid}, {4'b0010, 1'b0});
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk($sformatf("bp_hold%0d", k), {mem_req_valid, mem_req_thread, mem_req_addr},
                {1'b1, 2'd1, 32'h123});
            hs += int'(mem_req_valid & mem_req_ready);
        end
        cyc(); mem_req_ready = 1'b1; rsp(1); #1;
        chk("bp_accept", {mem_req_valid, mem_req_thread, mem_req_addr}, {1'b1, 2'd1, 32'h123});
        hs += int'(mem_req_valid & mem_req_ready);
        for (int k = 0; k < 2; k++) begin
            cyc(); mem_req_ready = 1'b1; #1;
            hs += int'(mem_req_valid & mem_req_ready);
        end
        chk("bp_one_handshake", hs, 1);
        chk("hs_rsp_err", {proto_err, miss_busy}, {1'b1, 4'b0010});

        // Reset while t0 waits; responses during reset are ignored.
        do_reset();
        miss_addr[0] = 32'h40;
        cyc(); miss_req = 4'b0001; mem_req_ready = 1'b1; #1;
        for (int k = 0; k < 4; k++) begin
            cyc(); mem_req_ready = 1'b1; #1;
        end
        chk("wait_busy", {miss_busy, mem_req_valid, proto_err}, {4'b0001, 1'b0, 1'b0});
        #1 reset = 1'b0;
        #1;
        chk("async_reset_outs", all_out(), 128'h0);
        cyc(); rsp(0); #1;
        chk("err_in_reset_a", proto_err, 1'b0);
        cyc(); rsp(0); #1;
        chk("err_in_reset_b", proto_err, 1'b0);
        cyc(); reset = 1'b1; rsp(0); #1;
        cyc(); #1;
        chk("late_rsp_err", {proto_err, miss_busy}, {1'b1, 4'b0000});
        cyc(); #1;
        chk("err_sticky", proto_err, 1'b1);

        // Single-threaded mode ignores misses on threads other than 0.
        do_reset();
        mt_mode      = Single_Threaded;
        miss_addr[1] = 32'h55;
        miss_addr[0] = 32'h66;
        cyc(); miss_req = 4'b0010; mem_req_ready = 1'b1; #1;
        cyc(); mem_req_ready = 1'b1; #1;
        chk("st_ignore_busy", miss_busy, 4'b0000);
        cyc(); mem_req_ready = 1'b1; #1;
        chk("st_ignore_req", mem_req_valid, 1'b0);
        cyc(); miss_req = 4'b0001; mem_req_ready = 1'b1; #1;
        cyc(); mem_req_ready = 1'b1; #1;
        chk("st_t0_busy", miss_busy, 4'b0001);
        cyc(); mem_req_ready = 1'b1; #1;
        chk("st_t0_req", {mem_req_valid, mem_req_thread, mem_req_addr}, {1'b1, 2'd0, 32'h66});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
